// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data-cache controller: FSM states and address-field geometry.
// No logic of its own; latency and backpressure are set by the controller.
package dcache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_REFILL,
    ST_FILL
  } state_t;

  // 16-byte lines of four 32-bit words: word select sits at addr[3:2], index starts at addr[4]
  localparam int OFF_W    = 4;
  localparam int WORD_W   = 32;
  localparam int WSEL_LSB = 2;
  localparam int WSEL_W   = 2;

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller; hit completes 1 cycle after accept, misses add writeback/refill waits.
// One request in flight: cpu_ready only in IDLE, mem_* held stable until mem_ack.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_rvalid,
  output logic [31:0]        cpu_rdata,
  output logic [INDEX_W-1:0] da_rindex,
  output logic [INDEX_W-1:0] da_windex,
  output logic               da_we,
  output logic [LINE_W-1:0]  da_wdata,
  input  logic [LINE_W-1:0]  da_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [LINE_W-1:0]  mem_rdata
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int NLINES = 1 << INDEX_W;

  state_t state_q, state_d;

  logic                 req_we_q;
  logic [TAG_W-1:0]     req_tag_q;
  logic [INDEX_W-1:0]   req_idx_q;
  logic [WSEL_W-1:0]    req_wsel_q;
  logic [WORD_W-1:0]    req_wdata_q;
  logic [LINE_W-1:0]    buf_q;

  logic [TAG_W-1:0]     tag_q [NLINES];
  logic [NLINES-1:0]    valid_q;
  logic [NLINES-1:0]    dirty_q;

  logic                 hit;
  logic                 victim_dirty;
  logic [LINE_W-1:0]    line_src;
  logic [LINE_W-1:0]    merged_line;

  // Byte-lane bits of the address never reach the word-granular datapath
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[WSEL_LSB-1:0];

  assign hit          = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);
  assign victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];
  assign da_rindex    = req_idx_q;
  assign da_windex    = req_idx_q;

  // A store hit merges into the array line; a store miss merges into the refilled buffer
  always_comb begin
    line_src = (state_q == ST_FILL) ? buf_q : da_rdata;
    merged_line = line_src;
    merged_line[req_wsel_q*WORD_W +: WORD_W] = req_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_wsel_q  <= '0;
      req_wdata_q <= '0;
      buf_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            req_we_q    <= cpu_we;
            req_tag_q   <= cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx_q   <= cpu_addr[OFF_W +: INDEX_W];
            req_wsel_q  <= cpu_addr[WSEL_LSB +: WSEL_W];
            req_wdata_q <= cpu_wdata;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            if (req_we_q) dirty_q[req_idx_q] <= 1'b1;
          end else begin
            buf_q <= da_rdata;
          end
        end
        ST_WB: begin
          if (mem_ack) dirty_q[req_idx_q] <= 1'b0;
        end
        ST_REFILL: begin
          if (mem_ack) buf_q <= mem_rdata;
        end
        ST_FILL: begin
          valid_q[req_idx_q] <= 1'b1;
          dirty_q[req_idx_q] <= req_we_q;
        end
        default: ;
      endcase
    end
  end

  // Tags are qualified by valid_q, so they need no reset
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) tag_q[req_idx_q] <= req_tag_q;
  end

  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    da_we      = 1'b0;
    da_wdata   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = line_src[req_wsel_q*WORD_W +: WORD_W];
          if (req_we_q) begin
            da_we    = 1'b1;
            da_wdata = merged_line;
          end
          state_d = ST_IDLE;
        end else if (victim_dirty) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx_q], req_idx_q, {OFF_W{1'b0}}};
        mem_wdata = buf_q;
        if (mem_ack) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        if (mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        da_we      = 1'b1;
        da_wdata   = req_we_q ? merged_line : buf_q;
        cpu_rvalid = 1'b1;
        cpu_rdata  = buf_q[req_wsel_q*WORD_W +: WORD_W];
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
